// File: rtl/reg_bank_mp.sv
// Parametrised multi-port register bank with optional zero register, same-cycle
// write bypass and a sequential clear engine that zeroes every entry after reset.
module reg_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    output logic                     busy,
    output logic                     clr_done
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              clr_done_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              zero_wa_s;
    logic              wr_en_s;

    assign busy     = (state_r == CLEAR);
    assign clr_done = clr_done_r;

    // Writes are accepted only once the clear engine has finished.
    assign zero_wa_s = (ZERO_REG != 0) && (wa == {ADDR_W{1'b0}});
    assign wr_en_s   = we && !rst && (state_r == READY) && !zero_wa_s;

    // Clear engine sequencing and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CLEAR;
            clr_ptr_r  <= {ADDR_W{1'b0}};
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= 1'b0;
            case (state_r)
                CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_ptr_r == LAST_PTR) begin
                        state_r    <= READY;
                        clr_done_r <= 1'b1;
                    end else begin
                        state_r <= CLEAR;
                    end
                end
                READY: begin
                    state_r <= READY;
                end
                default: begin
                    state_r <= CLEAR;
                end
            endcase
        end
    end

    // Storage array: zeroed entry by entry while clearing, else normal write port.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem_r[clr_ptr_r] <= {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            mem_r[wa] <= wd;
        end else begin
            mem_r[wa] <= mem_r[wa];
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] val_s;

        assign ra_s = ra[i*ADDR_W +: ADDR_W];

        // Zero register beats bypass; nothing but zeros is visible while clearing.
        always_comb begin
            val_s = {DATA_W{1'b0}};
            if (state_r != READY) begin
                val_s = {DATA_W{1'b0}};
            end else if ((ZERO_REG != 0) && (ra_s == {ADDR_W{1'b0}})) begin
                val_s = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && we && (ra_s == wa)) begin
                val_s = wd;
            end else begin
                val_s = mem_r[ra_s];
            end
        end

        assign rd[i*DATA_W +: DATA_W] = val_s;
    end

endmodule
